// File: rtl/dm_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the debug-module abstract command block:
//   - DMI register addresses (data0, data1, abstractcs, command)
//   - abstractcs.cmderr codes
//   - abstract command types and the data register count
//   - FSM state enum for the command sequencer
// -----------------------------------------------------------------------------
package dm_pkg;

    // DMI register map
    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DATA1      = 7'h05;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    // abstractcs.cmderr codes
    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    // Supported command types (cmd[31:24])
    localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_ACCESS_MEM = 8'd2;

    // Number of implemented data registers, reported in abstractcs[3:0]
    localparam logic [3:0] DATACOUNT = 4'd2;

    // Command sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_abstract.sv
// -----------------------------------------------------------------------------
// dm_abstract
// Abstract command block of a debug module: DMI register decode for data0,
// data1, abstractcs and command, plus the IDLE -> ISSUE -> WAIT sequencer that
// launches a command in the core and collects its result.
//
// Optional feature macro: DM_POSTINCR_EN
//   defined   : cmd[19] (postincrement) is accepted; after a successful
//               command, cmdtype 0 bumps cmd[15:0] by 1 and cmdtype 2 bumps
//               data1 by (1 << cmd[22:20]).
//   undefined : any command with cmd[19]=1 is rejected with cmderr=NOTSUP.
//
// Parameters
//   Timeout      core cycles allowed in WAIT before the command is aborted
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   dmi_addr     DMI register address
//   dmi_wdata    DMI write data
//   dmi_wr/rd    single-cycle access strobes (mutually exclusive)
//   dmi_rdata    registered read data, valid with dmi_ack
//   dmi_ack      one-cycle acknowledge, exactly one cycle after a strobe
//   core_halted  core is in debug halt
//   cmd_start    one-cycle launch pulse (the ISSUE cycle)
//   cmd          latched command word
//   data0_out    data0 to the core
//   data1_out    data1 to the core
//   data0_in     core result
//   cmd_done     core completion
//   cmd_err      core completion with error (qualified by cmd_done)
//   dbg_state    current sequencer state, for observation only
//
// Handshake: the DMI side has no backpressure. A dmi_wr/dmi_rd strobe is
// accepted in the cycle it is high; dmi_ack (with dmi_rdata for reads) is
// high in the following cycle. Read data is the register contents in the
// strobe cycle; a write takes effect at the end of the ack cycle.
// -----------------------------------------------------------------------------
module dm_abstract
    import dm_pkg::*;
#(
    parameter int Timeout = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  dmi_addr,
    input  logic [31:0] dmi_wdata,
    input  logic        dmi_wr,
    input  logic        dmi_rd,
    output logic [31:0] dmi_rdata,
    output logic        dmi_ack,
    input  logic        core_halted,
    output logic        cmd_start,
    output logic [31:0] cmd,
    output logic [31:0] data0_out,
    output logic [31:0] data1_out,
    input  logic [31:0] data0_in,
    input  logic        cmd_done,
    input  logic        cmd_err,
    output dm_state_e   dbg_state
);

    localparam int TW = $clog2(Timeout + 1);

    dm_state_e   state_q, state_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [31:0] data0_q, data0_d;
    logic [31:0] data1_q, data1_d;
    logic [31:0] cmd_q, cmd_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    // DMI write registered in the strobe cycle, applied during the ack cycle.
    // This places the ISSUE cycle two cycles after the command write.
    logic        req_wr_q;
    logic [6:0]  req_addr_q;
    logic [31:0] req_wdata_q;

    logic [31:0] rdata_q;
    logic        ack_q;
    logic [31:0] rd_mux;
    logic        busy;
    logic        postincr_ok;
    logic        cmd_supported;

    assign busy = (state_q != ST_IDLE);

`ifdef DM_POSTINCR_EN
    assign postincr_ok = 1'b1;
`else
    assign postincr_ok = ~req_wdata_q[19];
`endif

    assign cmd_supported = ((req_wdata_q[31:24] == CMDTYPE_ACCESS_REG) ||
                            (req_wdata_q[31:24] == CMDTYPE_ACCESS_MEM)) && postincr_ok;

    always_comb begin
        rd_mux = '0;
        case (dmi_addr)
            ADDR_DATA0:      rd_mux = data0_q;
            ADDR_DATA1:      rd_mux = data1_q;
            ADDR_ABSTRACTCS: rd_mux = {19'd0, busy, 1'b0, cmderr_q, 4'd0, DATACOUNT};
            ADDR_COMMAND:    rd_mux = cmd_q;
            default:         rd_mux = '0;
        endcase
    end

    // Next-state logic. DMI side effects are evaluated first; the sequencer's
    // own updates follow so that core completion (capture, EXCEPT) wins over
    // anything the DMI write did in the same cycle.
    always_comb begin
        state_d  = state_q;
        cmderr_d = cmderr_q;
        data0_d  = data0_q;
        data1_d  = data1_q;
        cmd_d    = cmd_q;
        tcnt_d   = tcnt_q;

        if (req_wr_q) begin
            case (req_addr_q)
                ADDR_DATA0: begin
                    if (busy) begin
                        if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                    end else begin
                        data0_d = req_wdata_q;
                    end
                end
                ADDR_DATA1: begin
                    if (busy) begin
                        if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                    end else begin
                        data1_d = req_wdata_q;
                    end
                end
                ADDR_ABSTRACTCS: begin
                    cmderr_d = cmderr_q & ~req_wdata_q[10:8];
                end
                ADDR_COMMAND: begin
                    if (busy) begin
                        if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                    end else if (cmderr_q == CMDERR_NONE) begin
                        cmd_d = req_wdata_q;
                        if (!cmd_supported)   cmderr_d = CMDERR_NOTSUP;
                        else if (!core_halted) cmderr_d = CMDERR_HALTRESUME;
                        else                  state_d  = ST_ISSUE;
                    end
                end
                default: ;
            endcase
        end

        case (state_q)
            ST_ISSUE: begin
                state_d = ST_WAIT;
                tcnt_d  = '0;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    state_d = ST_IDLE;
                    tcnt_d  = '0;
                    if (cmd_err) begin
                        cmderr_d = CMDERR_EXCEPT;
                    end else begin
                        if (!cmd_q[16]) data0_d = data0_in;
`ifdef DM_POSTINCR_EN
                        if (cmd_q[19]) begin
                            if (cmd_q[31:24] == CMDTYPE_ACCESS_REG)
                                cmd_d = {cmd_q[31:16], cmd_q[15:0] + 16'd1};
                            else if (cmd_q[31:24] == CMDTYPE_ACCESS_MEM)
                                data1_d = data1_q + (32'd1 << cmd_q[22:20]);
                        end
`endif
                    end
                end else if (tcnt_q == TW'(Timeout - 1)) begin
                    state_d  = ST_IDLE;
                    tcnt_d   = '0;
                    cmderr_d = CMDERR_EXCEPT;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmderr_q    <= CMDERR_NONE;
            data0_q     <= '0;
            data1_q     <= '0;
            cmd_q       <= '0;
            tcnt_q      <= '0;
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmderr_q    <= cmderr_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            cmd_q       <= cmd_d;
            tcnt_q      <= tcnt_d;
            req_wr_q    <= dmi_wr;
            req_addr_q  <= dmi_addr;
            req_wdata_q <= dmi_wdata;
            rdata_q     <= dmi_rd ? rd_mux : '0;
            ack_q       <= dmi_wr | dmi_rd;
        end
    end

    assign dmi_rdata = rdata_q;
    assign dmi_ack   = ack_q;
    assign cmd_start = (state_q == ST_ISSUE);
    assign cmd       = cmd_q;
    assign data0_out = data0_q;
    assign data1_out = data1_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_abstract.sv
// -----------------------------------------------------------------------------
// tb_dm_abstract
// Directed bench for dm_abstract. DMI reads push their expected data into a
// scoreboard queue; a monitor pops and compares on every dmi_ack. A small core
// model answers cmd_start with cmd_done after a programmable delay.
// -----------------------------------------------------------------------------
module tb_dm_abstract;
    import dm_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata;
    logic        dmi_wr;
    logic        dmi_rd;
    logic [31:0] dmi_rdata;
    logic        dmi_ack;
    logic        core_halted;
    logic        cmd_start;
    logic [31:0] cmd;
    logic [31:0] data0_out;
    logic [31:0] data1_out;
    logic [31:0] data0_in;
    logic        cmd_done;
    logic        cmd_err;
    dm_state_e   dbg_state;

    dm_abstract dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmi_addr   (dmi_addr),
        .dmi_wdata  (dmi_wdata),
        .dmi_wr     (dmi_wr),
        .dmi_rd     (dmi_rd),
        .dmi_rdata  (dmi_rdata),
        .dmi_ack    (dmi_ack),
        .core_halted(core_halted),
        .cmd_start  (cmd_start),
        .cmd        (cmd),
        .data0_out  (data0_out),
        .data1_out  (data1_out),
        .data0_in   (data0_in),
        .cmd_done   (cmd_done),
        .cmd_err    (cmd_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_wr_cyc = 0;
    int start_cnt = 0;
    logic strobe_d = 1'b0;

    // core model controls
    logic core_respond = 1'b1;
    logic core_fail = 1'b0;
    int   core_delay = 3;

    // scoreboard
    logic [31:0] exp_q[$];
    logic        chk_q[$];
    string       name_q[$];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        strobe_d <= rst_n ? (dmi_wr | dmi_rd) : 1'b0;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        exp_q.push_back(32'd0);
        chk_q.push_back(1'b0);
        name_q.push_back("write");
        if (addr == ADDR_COMMAND) cmd_wr_cyc = cyc;
        dmi_addr  = addr;
        dmi_wdata = data;
        dmi_wr    = 1'b1;
        @(posedge clk); #1;
        dmi_wr    = 1'b0;
        @(posedge clk);
    endtask

    task automatic dmi_read(input logic [6:0] addr, input logic [31:0] exp, input string name);
        @(posedge clk); #1;
        exp_q.push_back(exp);
        chk_q.push_back(1'b1);
        name_q.push_back(name);
        dmi_addr = addr;
        dmi_rd   = 1'b1;
        @(posedge clk); #1;
        dmi_rd   = 1'b0;
        @(posedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (dmi_ack !== strobe_d) begin
            check("ack_timing", {31'd0, dmi_ack}, {31'd0, strobe_d});
        end else if (dmi_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                logic        c;
                string       n;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = name_q.pop_front();
                if (c) check(n, dmi_rdata, e);
            end
        end
    end

    // ---------------- core model ----------------
    initial begin
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_start && rst_n) begin
                start_cnt++;
                check("start_latency", 32'(cyc - cmd_wr_cyc), 32'd2);
                if (core_respond) begin
                    repeat (core_delay) @(negedge clk);
                    cmd_done = 1'b1;
                    cmd_err  = core_fail;
                    @(negedge clk);
                    cmd_done = 1'b0;
                    cmd_err  = 1'b0;
                end
            end
        end
    end

    // ---------------- global watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        rst_n       = 1'b0;
        dmi_addr    = '0;
        dmi_wdata   = '0;
        dmi_wr      = 1'b0;
        dmi_rd      = 1'b0;
        core_halted = 1'b0;
        data0_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack",    {31'd0, dmi_ack}, 32'd0);
        check("rst_rdata",  dmi_rdata, 32'd0);
        check("rst_start",  {31'd0, cmd_start}, 32'd0);
        check("rst_cmd",    cmd, 32'd0);
        check("rst_data0",  data0_out, 32'd0);
        check("rst_data1",  data1_out, 32'd0);
        check("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;

        // register access basics
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_reset");
        dmi_read(ADDR_DATA0, 32'h0, "data0_reset");
        dmi_write(ADDR_DATA0, 32'h1234_5678);
        dmi_read(ADDR_DATA0, 32'h1234_5678, "data0_rw");
        dmi_write(ADDR_DATA1, 32'h0000_0100);
        dmi_read(ADDR_DATA1, 32'h0000_0100, "data1_rw");
        dmi_write(7'h11, 32'hFFFF_FFFF);
        dmi_read(7'h11, 32'h0, "unmapped");
        dmi_write(ADDR_ABSTRACTCS, 32'hFFFF_FFFF);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_ro_fields");

        // memory read command, core returns data
        core_halted = 1'b1;
        data0_in    = 32'hDEAD_BEEF;
        s = start_cnt;
        dmi_write(ADDR_COMMAND, 32'h0222_0000);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_1002, "acs_busy");
        repeat (10) @(posedge clk);
        dmi_read(ADDR_DATA0, 32'hDEAD_BEEF, "data0_capture");
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_done");
        check("cmd_latched", cmd, 32'h0222_0000);
        check("start_once", 32'(start_cnt - s), 32'd1);

        // write command (cmd[16]=1): data0 not captured
        data0_in = 32'h1111_1111;
        dmi_write(ADDR_COMMAND, 32'h0223_0000);
        repeat (10) @(posedge clk);
        dmi_read(ADDR_DATA0, 32'hDEAD_BEEF, "data0_nocapture");

        // core not halted
        core_halted = 1'b0;
        s = start_cnt;
        dmi_write(ADDR_COMMAND, 32'h0022_0300);
        repeat (5) @(posedge clk);
        check("no_start_unhalted", 32'(start_cnt - s), 32'd0);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0402, "acs_haltresume");
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0400);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_w1c_4");

        // unsupported cmdtype
        core_halted = 1'b1;
        dmi_write(ADDR_COMMAND, 32'h0100_0000);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0202, "acs_notsup");
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0700);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_w1c_2");

        // postincrement on memory access
        dmi_write(ADDR_DATA1, 32'hFFFF_FFFC);
        dmi_write(ADDR_COMMAND, 32'h022A_0000);
        repeat (10) @(posedge clk);
`ifdef DM_POSTINCR_EN
        dmi_read(ADDR_DATA1, 32'h0000_0000, "data1_postincr");
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_postincr");
`else
        dmi_read(ADDR_DATA1, 32'hFFFF_FFFC, "data1_no_postincr");
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0202, "acs_postincr_notsup");
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0200);
`endif

        // DMI write while busy
        dmi_write(ADDR_DATA0, 32'h0BAD_F00D);
        core_delay = 20;
        data0_in   = 32'h5A5A_5A5A;
        dmi_write(ADDR_COMMAND, 32'h0222_0000);
        dmi_write(ADDR_DATA0, 32'hAAAA_5555);
        dmi_read(ADDR_DATA0, 32'h0BAD_F00D, "data0_busy_unchanged");
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_1102, "acs_busy_err");
        repeat (30) @(posedge clk);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0102, "acs_err_kept");
        dmi_read(ADDR_DATA0, 32'h5A5A_5A5A, "data0_after_busy");
        core_delay = 3;
        s = start_cnt;
        dmi_write(ADDR_COMMAND, 32'h0022_0300);
        repeat (5) @(posedge clk);
        check("cmd_ignored_start", 32'(start_cnt - s), 32'd0);
        check("cmd_ignored_latch", cmd, 32'h0222_0000);
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0100);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_w1c_1");
        data0_in = 32'h1357_9BDF;
        dmi_write(ADDR_COMMAND, 32'h0022_0300);
        repeat (10) @(posedge clk);
        check("cmd_accepted_start", 32'(start_cnt - s), 32'd1);
        check("cmd_accepted_latch", cmd, 32'h0022_0300);
        dmi_read(ADDR_DATA0, 32'h1357_9BDF, "data0_reg_cmd");

        // core reports an error
        core_fail = 1'b1;
        data0_in  = 32'hFFFF_0000;
        dmi_write(ADDR_COMMAND, 32'h0222_0000);
        repeat (10) @(posedge clk);
        core_fail = 1'b0;
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0302, "acs_except");
        dmi_read(ADDR_DATA0, 32'h1357_9BDF, "data0_err_nocapture");
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0300);

        // timeout: core never completes
        core_respond = 1'b0;
        dmi_write(ADDR_COMMAND, 32'h0222_0000);
        repeat (1020) @(posedge clk);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_1002, "acs_before_timeout");
        repeat (10) @(posedge clk);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0302, "acs_timeout");
        dmi_write(ADDR_ABSTRACTCS, 32'h0000_0300);
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_w1c_3");

        // reset during WAIT
        dmi_write(ADDR_DATA1, 32'h0000_0040);
        dmi_write(ADDR_COMMAND, 32'h0222_0000);
        repeat (5) @(posedge clk);
        check("wait_before_reset", 32'(dbg_state), 32'(ST_WAIT));
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_wait_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_wait_data0", data0_out, 32'd0);
        check("rst_wait_data1", data1_out, 32'd0);
        check("rst_wait_cmd",   cmd, 32'd0);
        check("rst_wait_ack",   {31'd0, dmi_ack}, 32'd0);
        check("rst_wait_start", {31'd0, cmd_start}, 32'd0);
        rst_n = 1'b1;
        core_respond = 1'b1;
        dmi_read(ADDR_ABSTRACTCS, 32'h0000_0002, "acs_after_reset");

        repeat (5) @(posedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
